// File: rtl/dm_arbiter.sv
// dm_arbiter: CPU (port C) / auxiliary master (port A) arbiter for the single-ported data memory.
// Build option DM_ARB_RR_EN selects round-robin contention handling instead of CPU priority with a port-A starvation guard.
module dm_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_W    = 13,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_re,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              a_re,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              dm_re,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              err,
    output logic [3:0]        starve_cnt
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_A    = 2'd2
    } owner_e;

    owner_e              r_owner;
    owner_e              w_owner_nxt;
    logic                r_rd_bad;
    logic                r_err;
    logic                r_c_rvalid;
    logic                r_a_rvalid;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_c_req;
    logic                w_a_req;
    logic                w_c_gnt;
    logic                w_a_gnt;
    logic                w_gnt_any;
    logic                w_sel_re;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_bad;

`ifdef DM_ARB_RR_EN
    logic                r_rr_last_a;
    logic                w_rr_last_a_nxt;
`else
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
`endif

    assign w_c_req = c_re | c_we;
    assign w_a_req = a_re | a_we;

    // Grant decision and contention bookkeeping
    always_comb begin
        w_c_gnt = 1'b0;
        w_a_gnt = 1'b0;
`ifdef DM_ARB_RR_EN
        w_rr_last_a_nxt = r_rr_last_a;
        if (w_c_req && w_a_req) begin
            w_c_gnt         = r_rr_last_a;
            w_a_gnt         = ~r_rr_last_a;
            w_rr_last_a_nxt = ~r_rr_last_a;
        end else begin
            w_c_gnt = w_c_req;
            w_a_gnt = w_a_req;
        end
`else
        w_cnt_nxt = '0;
        if (w_c_req && w_a_req) begin
            if (r_cnt == CNT_W'(STARVE_MAX)) begin
                w_a_gnt = 1'b1;
            end else begin
                w_c_gnt   = 1'b1;
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else begin
            w_c_gnt = w_c_req;
            w_a_gnt = w_a_req;
        end
`endif
    end

    // Memory-side mux, owner next state and read-data routing
    always_comb begin
        w_gnt_any   = w_c_gnt | w_a_gnt;
        w_sel_re    = c_re;
        w_sel_we    = c_we;
        w_sel_addr  = c_addr;
        w_sel_wdata = c_wdata;
        w_owner_nxt = OWN_NONE;
        if (w_a_gnt) begin
            w_sel_re    = a_re;
            w_sel_we    = a_we;
            w_sel_addr  = a_addr;
            w_sel_wdata = a_wdata;
            w_owner_nxt = OWN_A;
        end else if (w_c_gnt) begin
            w_owner_nxt = OWN_C;
        end
        w_sel_bad = (w_sel_re & w_sel_we) | ((w_sel_addr >> DEPTH_W) != '0);

        dm_re    = rst_n & w_gnt_any & ~w_sel_bad & w_sel_re;
        dm_we    = rst_n & w_gnt_any & ~w_sel_bad & w_sel_we;
        dm_addr  = w_gnt_any ? w_sel_addr  : r_addr;
        dm_wdata = w_gnt_any ? w_sel_wdata : r_wdata;

        c_gnt    = w_c_gnt;
        a_gnt    = w_a_gnt;
        c_rvalid = r_c_rvalid;
        a_rvalid = r_a_rvalid;
        c_rdata  = '0;
        a_rdata  = '0;
        if (r_owner == OWN_C && r_c_rvalid && !r_rd_bad) begin
            c_rdata = dm_rdata;
        end
        if (r_owner == OWN_A && r_a_rvalid && !r_rd_bad) begin
            a_rdata = dm_rdata;
        end
    end

    // Owner state and completion registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWN_NONE;
            r_rd_bad   <= 1'b0;
            r_err      <= 1'b0;
            r_c_rvalid <= 1'b0;
            r_a_rvalid <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_rd_bad   <= w_gnt_any & w_sel_bad;
            r_err      <= r_err | (w_gnt_any & w_sel_bad);
            r_c_rvalid <= w_c_gnt & c_re;
            r_a_rvalid <= w_a_gnt & a_re;
            if (w_gnt_any) begin
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
        end
    end

`ifdef DM_ARB_RR_EN
    // Round-robin pointer: C wins the first contention after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last_a <= 1'b1;
        end else begin
            r_rr_last_a <= w_rr_last_a_nxt;
        end
    end

    assign starve_cnt = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign starve_cnt = r_cnt;
`endif

    assign err = r_err;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized and directed bench for dm_arbiter against a transaction-level reference model.
// Define DM_ARB_RR_EN for both bench and design to exercise the round-robin build.
module tb_dm_arbiter;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned DEPTH_W = 13;
    localparam int unsigned SMAX    = 4;
    localparam int unsigned MEM_N   = 1 << DEPTH_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              c_re = 1'b0, c_we = 1'b0, a_re = 1'b0, a_we = 1'b0;
    logic [ADDR_W-1:0] c_addr = '0, a_addr = '0;
    logic [DATA_W-1:0] c_wdata = '0, a_wdata = '0;
    logic              c_gnt, c_rvalid, a_gnt, a_rvalid, dm_re, dm_we, err;
    logic [DATA_W-1:0] c_rdata, a_rdata, dm_wdata;
    logic [DATA_W-1:0] dm_rdata = '0;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        starve_cnt;

    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_re(c_re), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .a_re(a_re), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .err(err), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    // Data memory: samples on the falling edge
    logic [DATA_W-1:0] mem [MEM_N];
    always @(negedge clk) begin
        if (dm_we) mem[dm_addr[DEPTH_W-1:0]] <= dm_wdata;
        if (dm_re) dm_rdata <= mem[dm_addr[DEPTH_W-1:0]];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state (transaction level)
    logic [DATA_W-1:0] ref_mem [MEM_N];
    int                m_cnt;
    bit                m_rr_last_a;
    int                m_owner;      // 0 none, 1 C, 2 A
    bit                m_rd, m_bad, m_err;
    logic [ADDR_W-1:0] m_last_addr;
    logic [DATA_W-1:0] m_last_wdata, m_exp_rdata;
    bit                m_gc, m_ga;

    logic              s_c_gnt, s_a_gnt, s_dm_re, s_dm_we, s_c_rvalid, s_a_rvalid, s_err;
    logic [DATA_W-1:0] s_c_rdata, s_a_rdata;
    logic [ADDR_W-1:0] s_dm_addr;
    logic [3:0]        s_starve;

    bit c_pend = 0, a_pend = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt        = 0;
        m_rr_last_a  = 1'b1;
        m_owner      = 0;
        m_rd         = 1'b0;
        m_bad        = 1'b0;
        m_err        = 1'b0;
        m_last_addr  = '0;
        m_last_wdata = '0;
    endtask

    // Called at posedge+1 with inputs applied; checks, advances model, returns at next posedge+1
    task automatic step(input bit rst_mid);
        bit creq, areq, gany, sre, swe, bad, ecv, eav;
        logic [ADDR_W-1:0] saddr;
        logic [DATA_W-1:0] swd;
        #2;
        creq = c_re | c_we;
        areq = a_re | a_we;
        if (creq && areq) begin
`ifdef DM_ARB_RR_EN
            m_gc = m_rr_last_a;
`else
            m_gc = (m_cnt != SMAX);
`endif
            m_ga = !m_gc;
        end else begin
            m_gc = creq;
            m_ga = areq && !creq;
        end
        gany  = m_gc | m_ga;
        sre   = m_ga ? a_re : c_re;
        swe   = m_ga ? a_we : c_we;
        saddr = m_ga ? a_addr : c_addr;
        swd   = m_ga ? a_wdata : c_wdata;
        bad   = (sre && swe) || (32'(saddr) >= MEM_N);
        ecv   = (m_owner == 1) && m_rd;
        eav   = (m_owner == 2) && m_rd;

        chk("c_gnt", 32'(c_gnt), 32'(m_gc));
        chk("a_gnt", 32'(a_gnt), 32'(m_ga));
        chk("dm_re", 32'(dm_re), 32'(rst_n && gany && !bad && sre));
        chk("dm_we", 32'(dm_we), 32'(rst_n && gany && !bad && swe));
        chk("dm_addr", 32'(dm_addr), 32'(gany ? saddr : m_last_addr));
        chk("dm_wdata", 32'(dm_wdata), 32'(gany ? swd : m_last_wdata));
        chk("c_rvalid", 32'(c_rvalid), 32'(ecv));
        chk("a_rvalid", 32'(a_rvalid), 32'(eav));
        if (ecv) chk("c_rdata", 32'(c_rdata), 32'(m_bad ? 16'h0 : m_exp_rdata));
        if (eav) chk("a_rdata", 32'(a_rdata), 32'(m_bad ? 16'h0 : m_exp_rdata));
        chk("err", 32'(err), 32'(m_err));
`ifdef DM_ARB_RR_EN
        chk("starve_cnt", 32'(starve_cnt), 32'h0);
`else
        chk("starve_cnt", 32'(starve_cnt), 32'(m_cnt));
`endif
        s_c_gnt = c_gnt; s_a_gnt = a_gnt; s_dm_re = dm_re; s_dm_we = dm_we;
        s_dm_addr = dm_addr; s_c_rvalid = c_rvalid; s_a_rvalid = a_rvalid;
        s_c_rdata = c_rdata; s_a_rdata = a_rdata; s_err = err; s_starve = starve_cnt;

        if (!rst_n) begin
            model_reset();
        end else begin
            if (gany) begin
                m_last_addr  = saddr;
                m_last_wdata = swd;
                m_owner      = m_gc ? 1 : 2;
                m_rd         = sre;
                m_bad        = bad;
                if (bad) m_err = 1'b1;
                else if (sre) m_exp_rdata = ref_mem[saddr[DEPTH_W-1:0]];
                else ref_mem[saddr[DEPTH_W-1:0]] = swd;
            end else begin
                m_owner = 0;
                m_rd    = 1'b0;
                m_bad   = 1'b0;
            end
            if (creq && areq) begin
                m_rr_last_a = m_ga;
                m_cnt       = m_ga ? 0 : m_cnt + 1;
            end else begin
                m_cnt = 0;
            end
        end
        if (rst_mid) begin
            #4;
            rst_n = 1'b0;
            model_reset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_re = 0; c_we = 0; a_re = 0; a_we = 0;
    endtask

    task automatic gen_port(input bit pend_in, input bit granted, output bit pend_out,
                            output logic re, output logic we,
                            output logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] wd,
                            input logic re_h, input logic we_h,
                            input logic [ADDR_W-1:0] addr_h, input logic [DATA_W-1:0] wd_h);
        int r;
        re = re_h; we = we_h; addr = addr_h; wd = wd_h; pend_out = pend_in;
        if (!pend_in || granted) begin
            pend_out = 0; re = 0; we = 0;
            if ($urandom_range(0, 99) < 70) begin
                pend_out = 1;
                r = int'($urandom_range(0, 99));
                re = (r < 50) || (r >= 96);
                we = (r >= 50);
                addr = ($urandom_range(0, 99) < 4) ? (16'h2000 | ADDR_W'($urandom_range(0, 255)))
                                                   : ADDR_W'($urandom_range(0, 31));
                wd = DATA_W'($urandom);
            end
        end
    endtask

    initial begin
        bit exp_c;
        for (int i = 0; i < int'(MEM_N); i++) begin
            mem[i]     = 16'(i * 7 + 3);
            ref_mem[i] = 16'(i * 7 + 3);
        end
        mem[16]     = 16'hBEEF;
        ref_mem[16] = 16'hBEEF;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state
        step(0);
        step(0);
        chk("lit_rst_c_rvalid", 32'(s_c_rvalid), 32'h0);
        chk("lit_rst_err", 32'(s_err), 32'h0);
        chk("lit_rst_starve", 32'(s_starve), 32'h0);
        rst_n = 1'b1;
        step(0);

        // Single CPU read of preloaded word
        c_re = 1; c_addr = 16'h0010;
        step(0);
        chk("lit_rd_c_gnt", 32'(s_c_gnt), 32'h1);
        chk("lit_rd_dm_re", 32'(s_dm_re), 32'h1);
        chk("lit_rd_dm_addr", 32'(s_dm_addr), 32'h0010);
        idle();
        step(0);
        chk("lit_rd_c_rvalid", 32'(s_c_rvalid), 32'h1);
        chk("lit_rd_c_rdata", 32'(s_c_rdata), 32'hBEEF);
        chk("lit_rd_a_rvalid", 32'(s_a_rvalid), 32'h0);

        // Port A write, then CPU read back
        a_we = 1; a_addr = 16'h0100; a_wdata = 16'h1234;
        step(0);
        chk("lit_wr_a_gnt", 32'(s_a_gnt), 32'h1);
        chk("lit_wr_dm_we", 32'(s_dm_we), 32'h1);
        idle();
        c_re = 1; c_addr = 16'h0100;
        step(0);
        idle();
        step(0);
        chk("lit_wr_c_rdata", 32'(s_c_rdata), 32'h1234);

        // Continuous contention
        c_re = 1; c_addr = 16'h0001; a_re = 1; a_addr = 16'h0002;
        for (int i = 0; i < 10; i++) begin
            step(0);
`ifdef DM_ARB_RR_EN
            exp_c = (i % 2 == 0);
            chk("lit_cont_starve", 32'(s_starve), 32'h0);
`else
            exp_c = (i % 5 != 4);
            chk("lit_cont_starve", 32'(s_starve), 32'(i % 5));
`endif
            chk("lit_cont_c_gnt", 32'(s_c_gnt), 32'(exp_c));
            chk("lit_cont_a_gnt", 32'(s_a_gnt), 32'(!exp_c));
        end
        idle();
        step(0);

        // Illegal and out-of-range accesses
        c_re = 1; c_we = 1; c_addr = 16'h0005;
        step(0);
        chk("lit_ill_c_gnt", 32'(s_c_gnt), 32'h1);
        chk("lit_ill_dm_re", 32'(s_dm_re), 32'h0);
        chk("lit_ill_dm_we", 32'(s_dm_we), 32'h0);
        chk("lit_ill_err_before", 32'(s_err), 32'h0);
        idle();
        a_re = 1; a_addr = 16'h2000;
        step(0);
        chk("lit_ill_err", 32'(s_err), 32'h1);
        chk("lit_oor_a_gnt", 32'(s_a_gnt), 32'h1);
        chk("lit_oor_dm_re", 32'(s_dm_re), 32'h0);
        idle();
        step(0);
        chk("lit_oor_a_rvalid", 32'(s_a_rvalid), 32'h1);
        chk("lit_oor_a_rdata", 32'(s_a_rdata), 32'h0);

        // Randomized traffic with held requests
        for (int n = 0; n < 3000; n++) begin
            gen_port(c_pend, m_gc, c_pend, c_re, c_we, c_addr, c_wdata, c_re, c_we, c_addr, c_wdata);
            gen_port(a_pend, m_ga, a_pend, a_re, a_we, a_addr, a_wdata, a_re, a_we, a_addr, a_wdata);
            step(0);
        end
        idle();
        step(0);
        step(0);

        // Reset between grant and read completion
        c_re = 1; c_addr = 16'h0040;
        step(1);
        idle();
        step(0);
        chk("lit_mid_rst_c_rvalid", 32'(s_c_rvalid), 32'h0);
        chk("lit_mid_rst_err", 32'(s_err), 32'h0);
        chk("lit_mid_rst_starve", 32'(s_starve), 32'h0);
        rst_n = 1'b1;
        step(0);
        c_re = 1; c_addr = 16'h0040;
        step(0);
        idle();
        step(0);
        chk("lit_post_rst_c_rvalid", 32'(s_c_rvalid), 32'h1);
        chk("lit_post_rst_c_rdata", 32'(s_c_rdata), 32'h01C3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
